// File: rtl/dmem_if.sv
// -----------------------------------------------------------------------------
// dmem_if
// Bundle for the data port between the mips789 core (master) and the
// data-memory responder (slave).
//   addr     : byte address; bit31 selects RAM (0) or IO (1)
//   wdata    : lane-replicated store data
//   wr_en    : byte-lane write enables, bit3 = bits[31:24]
//   rdata    : registered read data, one cycle after the address
//   gpio_out : GPIO register contents
//   irq      : timer interrupt level
// -----------------------------------------------------------------------------
interface dmem_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wr_en;
    logic [31:0] rdata;
    logic [31:0] gpio_out;
    logic        irq;

    modport master (
        output addr,
        output wdata,
        output wr_en,
        input  rdata,
        input  gpio_out,
        input  irq
    );

    modport slave (
        input  addr,
        input  wdata,
        input  wr_en,
        output rdata,
        output gpio_out,
        output irq
    );
endinterface

// File: rtl/dmem_slave.sv
// -----------------------------------------------------------------------------
// dmem_slave
// Data-memory responder for the mips789 core. The low half of the address
// space is a synchronous RAM with byte-lane writes; the high half is a small
// register file: TIMER, CMP, CTRL, STATUS (timer match, W1C) and GPIO.
// Both regions return read data exactly one cycle after the address.
// Ports:
//   clk : clock, all state updates on posedge
//   rst : synchronous active-high reset (IO registers and rdata only)
//   bus : dmem_if.slave (addr, wdata, wr_en in; rdata, gpio_out, irq out)
// -----------------------------------------------------------------------------
module dmem_slave #(
    parameter int ADDR_W = 10
) (
    input  logic   clk,
    input  logic   rst,
    dmem_if.slave  bus
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [2:0] SEL_TIMER  = 3'd0;
    localparam logic [2:0] SEL_CMP    = 3'd1;
    localparam logic [2:0] SEL_CTRL   = 3'd2;
    localparam logic [2:0] SEL_STATUS = 3'd3;
    localparam logic [2:0] SEL_GPIO   = 3'd4;

    // RAM storage, deliberately without reset
    logic [31:0] mem_q [DEPTH];

    logic [31:0] rdata_q,  rdata_d;
    logic [31:0] timer_q,  timer_d;
    logic [31:0] cmp_q,    cmp_d;
    logic [1:0]  ctrl_q,   ctrl_d;
    logic        status_q, status_d;
    logic [31:0] gpio_q,   gpio_d;

    logic [ADDR_W-1:0] ram_idx_s;
    logic              is_io_s;
    logic [2:0]        io_sel_s;
    logic              io_wr_s;
    logic [3:0]        ram_we_s;
    logic              match_s;
    logic [31:0]       io_rdata_s;
    logic              unused_addr_s;

    assign ram_idx_s = bus.addr[ADDR_W+1:2];
    assign is_io_s   = bus.addr[31];
    assign io_sel_s  = bus.addr[4:2];
    // Partial enables never reach the register file
    assign io_wr_s   = is_io_s && (bus.wr_en == 4'b1111);
    assign ram_we_s  = (!is_io_s && !rst) ? bus.wr_en : 4'b0000;
    // Compare uses the values held during this cycle, before any update
    assign match_s   = ctrl_q[0] && (timer_q == cmp_q);

    // Alias bits of the address are intentionally ignored
    assign unused_addr_s = ^{bus.addr[30:ADDR_W+2], bus.addr[1:0]};

    // IO read mux (pre-write register values)
    always_comb begin
        io_rdata_s = 32'h0000_0000;
        case (io_sel_s)
            SEL_TIMER:  io_rdata_s = timer_q;
            SEL_CMP:    io_rdata_s = cmp_q;
            SEL_CTRL:   io_rdata_s = {30'b0, ctrl_q};
            SEL_STATUS: io_rdata_s = {31'b0, status_q};
            SEL_GPIO:   io_rdata_s = gpio_q;
            default:    io_rdata_s = 32'h0000_0000;
        endcase
    end

    // Next-state for read data and the IO register file
    always_comb begin
        rdata_d  = 32'h0000_0000;
        timer_d  = timer_q;
        cmp_d    = cmp_q;
        ctrl_d   = ctrl_q;
        status_d = status_q;
        gpio_d   = gpio_q;

        if (is_io_s) begin
            rdata_d = io_rdata_s;
        end else begin
            rdata_d = mem_q[ram_idx_s];
        end

        // A software write takes priority over counting
        if (io_wr_s && (io_sel_s == SEL_TIMER)) begin
            timer_d = bus.wdata;
        end else if (ctrl_q[0]) begin
            timer_d = timer_q + 32'd1;
        end else begin
            timer_d = timer_q;
        end

        if (io_wr_s && (io_sel_s == SEL_CMP)) begin
            cmp_d = bus.wdata;
        end else begin
            cmp_d = cmp_q;
        end

        if (io_wr_s && (io_sel_s == SEL_CTRL)) begin
            ctrl_d = bus.wdata[1:0];
        end else begin
            ctrl_d = ctrl_q;
        end

        // Set beats a simultaneous write-1-to-clear
        if (match_s) begin
            status_d = 1'b1;
        end else if (io_wr_s && (io_sel_s == SEL_STATUS) && bus.wdata[0]) begin
            status_d = 1'b0;
        end else begin
            status_d = status_q;
        end

        if (io_wr_s && (io_sel_s == SEL_GPIO)) begin
            gpio_d = bus.wdata;
        end else begin
            gpio_d = gpio_q;
        end
    end

    // Register update for read data and IO registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q  <= 32'h0000_0000;
            timer_q  <= 32'h0000_0000;
            cmp_q    <= 32'hFFFF_FFFF;
            ctrl_q   <= 2'b00;
            status_q <= 1'b0;
            gpio_q   <= 32'h0000_0000;
        end else begin
            rdata_q  <= rdata_d;
            timer_q  <= timer_d;
            cmp_q    <= cmp_d;
            ctrl_q   <= ctrl_d;
            status_q <= status_d;
            gpio_q   <= gpio_d;
        end
    end

    // Byte-lane RAM write; untouched lanes keep their contents
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ram_we_s[i]) begin
                mem_q[ram_idx_s][8*i +: 8] <= bus.wdata[8*i +: 8];
            end
        end
    end

    assign bus.rdata    = rdata_q;
    assign bus.gpio_out = gpio_q;
    // Derived only from registers, so no combinational path from inputs
    assign bus.irq      = status_q & ctrl_q[1];

endmodule

// File: tb/tb_dmem_slave.sv
module tb_dmem_slave;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    dmem_if bus ();

    dmem_slave #(.ADDR_W(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wr_en;
        logic        chk;
        logic [31:0] exp_rdata;
        logic [31:0] exp_gpio;
    } vec_t;

    typedef struct {
        logic        chk;
        logic [31:0] exp;
        int          id;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   checks = 0;
    int   errors = 0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one cycle; expected read data is queued and popped after the edge
    task automatic step(input logic [31:0] a, input logic [31:0] w, input logic [3:0] we,
                        input logic r, input logic c, input logic [31:0] exp, input int id);
        sb_t e;
        @(negedge clk);
        bus.addr  = a;
        bus.wdata = w;
        bus.wr_en = we;
        rst       = r;
        e.chk = c;
        e.exp = exp;
        e.id  = id;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: queue empty at step %0d", id);
        end else begin
            e = sb.pop_front();
            if (e.chk) begin
                chk32($sformatf("rdata step %0d", e.id), bus.rdata, e.exp);
            end
        end
    endtask

    task automatic add(input logic [31:0] a, input logic [31:0] w, input logic [3:0] we,
                       input logic c, input logic [31:0] er, input logic [31:0] eg);
        vec_t v;
        v.addr = a; v.wdata = w; v.wr_en = we; v.chk = c; v.exp_rdata = er; v.exp_gpio = eg;
        vecs.push_back(v);
    endtask

    localparam logic [31:0] A_TIMER  = 32'h8000_0000;
    localparam logic [31:0] A_CMP    = 32'h8000_0004;
    localparam logic [31:0] A_CTRL   = 32'h8000_0008;
    localparam logic [31:0] A_STATUS = 32'h8000_000C;
    localparam logic [31:0] A_GPIO   = 32'h8000_0010;

    initial begin
        // RAM byte lanes
        add(32'h0000_0100, 32'hAABB_CCDD, 4'b1111, 1'b0, 32'h0, 32'h0);
        add(32'h0000_0100, 32'h1111_1111, 4'b0100, 1'b0, 32'h0, 32'h0);
        add(32'h0000_0100, 32'h0,         4'b0000, 1'b1, 32'hAA11_CCDD, 32'h0);
        add(32'h0000_0100, 32'h0000_00EE, 4'b0001, 1'b1, 32'hAA11_CCDD, 32'h0);
        add(32'h0000_0100, 32'h9900_0000, 4'b1000, 1'b1, 32'hAA11_CCEE, 32'h0);
        add(32'h0000_0100, 32'h0,         4'b0000, 1'b1, 32'h9911_CCEE, 32'h0);
        // Read-before-write
        add(32'h0000_0200, 32'hDEAD_BEEF, 4'b1111, 1'b0, 32'h0, 32'h0);
        add(32'h0000_0200, 32'h1234_5678, 4'b1111, 1'b1, 32'hDEAD_BEEF, 32'h0);
        add(32'h0000_0200, 32'h0,         4'b0000, 1'b1, 32'h1234_5678, 32'h0);
        // Aliasing
        add(32'h0000_0004, 32'h5555_5555, 4'b1111, 1'b0, 32'h0, 32'h0);
        add(32'h0000_1004, 32'h0,         4'b0000, 1'b1, 32'h5555_5555, 32'h0);
        add(32'h7FFF_F004, 32'h0,         4'b0000, 1'b1, 32'h5555_5555, 32'h0);
        // IO guards and decode
        add(A_GPIO,        32'h1234_5678, 4'b0011, 1'b1, 32'h0, 32'h0);
        add(A_GPIO,        32'hCAFE_F00D, 4'b1111, 1'b1, 32'h0, 32'hCAFE_F00D);
        add(A_GPIO,        32'h0,         4'b0000, 1'b1, 32'hCAFE_F00D, 32'hCAFE_F00D);
        add(32'h8000_0018, 32'hFFFF_FFFF, 4'b1111, 1'b1, 32'h0, 32'hCAFE_F00D);
        add(32'h8000_0018, 32'h0,         4'b0000, 1'b1, 32'h0, 32'hCAFE_F00D);
        add(32'h8000_00F0, 32'h0,         4'b0000, 1'b1, 32'hCAFE_F00D, 32'hCAFE_F00D);
        add(A_CMP,         32'h0,         4'b0000, 1'b1, 32'hFFFF_FFFF, 32'hCAFE_F00D);
        add(A_CTRL,        32'h0,         4'b0000, 1'b1, 32'h0, 32'hCAFE_F00D);
        add(A_TIMER,       32'h0,         4'b0000, 1'b1, 32'h0, 32'hCAFE_F00D);

        bus.addr  = 32'h0;
        bus.wdata = 32'h0;
        bus.wr_en = 4'b0000;
        rst       = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk32("reset rdata", bus.rdata, 32'h0);
        chk32("reset gpio_out", bus.gpio_out, 32'h0);
        chk32("reset irq", {31'b0, bus.irq}, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].addr, vecs[i].wdata, vecs[i].wr_en, 1'b0, vecs[i].chk, vecs[i].exp_rdata, i);
            chk32($sformatf("gpio_out vec %0d", i), bus.gpio_out, vecs[i].exp_gpio);
        end

        // Timer: CMP=5, enable with irq_en; irq rises on the 6th edge after enable
        step(A_CMP,  32'd5, 4'b1111, 1'b0, 1'b0, 32'h0, 100);
        step(A_CTRL, 32'd3, 4'b1111, 1'b0, 1'b0, 32'h0, 101);
        for (int k = 1; k <= 6; k++) begin
            step(32'h0000_0100, 32'h0, 4'b0000, 1'b0, 1'b0, 32'h0, 101 + k);
            chk32($sformatf("irq edge %0d", k), {31'b0, bus.irq}, (k == 6) ? 32'd1 : 32'd0);
        end
        step(A_TIMER,  32'h0, 4'b0000, 1'b0, 1'b1, 32'd6, 110);
        step(A_STATUS, 32'h1, 4'b1111, 1'b0, 1'b1, 32'd1, 111);
        chk32("irq after W1C", {31'b0, bus.irq}, 32'h0);
        // Match and clear in the same cycle: set wins
        step(A_TIMER,  32'd3, 4'b1111, 1'b0, 1'b0, 32'h0, 112);
        step(32'h0000_0100, 32'h0, 4'b0000, 1'b0, 1'b0, 32'h0, 113);
        step(32'h0000_0100, 32'h0, 4'b0000, 1'b0, 1'b0, 32'h0, 114);
        step(A_STATUS, 32'h1, 4'b1111, 1'b0, 1'b1, 32'd0, 115);
        chk32("irq match+clear", {31'b0, bus.irq}, 32'd1);
        step(A_STATUS, 32'h1, 4'b1111, 1'b0, 1'b1, 32'd1, 116);
        chk32("irq cleared", {31'b0, bus.irq}, 32'h0);
        // TIMER write during the match cycle still sets STATUS
        step(A_TIMER,  32'd5,   4'b1111, 1'b0, 1'b0, 32'h0, 117);
        step(A_TIMER,  32'd100, 4'b1111, 1'b0, 1'b1, 32'd5, 118);
        chk32("irq match on timer write", {31'b0, bus.irq}, 32'd1);
        step(A_TIMER,  32'h0, 4'b0000, 1'b0, 1'b1, 32'd100, 119);

        // Reset mid-run
        step(A_TIMER, 32'h7FFF_FFFF, 4'b1111, 1'b0, 1'b0, 32'h0, 120);
        step(A_GPIO,  32'hA5A5_A5A5, 4'b1111, 1'b0, 1'b0, 32'h0, 121);
        chk32("gpio before reset", bus.gpio_out, 32'hA5A5_A5A5);
        step(32'h0000_0200, 32'h0, 4'b0000, 1'b1, 1'b1, 32'h0, 122);
        chk32("irq at reset", {31'b0, bus.irq}, 32'h0);
        chk32("gpio at reset", bus.gpio_out, 32'h0);
        step(A_TIMER,  32'h0, 4'b0000, 1'b0, 1'b1, 32'h0,         123);
        step(A_TIMER,  32'h0, 4'b0000, 1'b0, 1'b1, 32'h0,         124);
        step(A_CMP,    32'h0, 4'b0000, 1'b0, 1'b1, 32'hFFFF_FFFF, 125);
        step(A_CTRL,   32'h0, 4'b0000, 1'b0, 1'b1, 32'h0,         126);
        step(A_STATUS, 32'h0, 4'b0000, 1'b0, 1'b1, 32'h0,         127);
        step(32'h0000_0200, 32'h0, 4'b0000, 1'b0, 1'b1, 32'h1234_5678, 128);
        step(32'h0000_0100, 32'h0, 4'b0000, 1'b0, 1'b1, 32'h9911_CCEE, 129);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
